// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit RISC CPU; all strobes registered (decoded from next state).
// Optional SINGLE_STEP_EN adds a `step` input that parks the FSM after S7 until a step rising edge.
module cpu_controller #(
  parameter logic [2:0] HLT_OP = 3'b000,
  parameter logic [2:0] SKZ_OP = 3'b001,
  parameter logic [2:0] ADD_OP = 3'b010,
  parameter logic [2:0] AND_OP = 3'b011,
  parameter logic [2:0] XOR_OP = 3'b100,
  parameter logic [2:0] LDA_OP = 3'b101,
  parameter logic [2:0] STO_OP = 3'b110,
  parameter logic [2:0] JMP_OP = 3'b111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       inc_pc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       alu_c,
  output logic       halt
);

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_S6,
    ST_S7,
`ifdef SINGLE_STEP_EN
    ST_STEP_WAIT,
`endif
    ST_HALTED
  } state_t;

  state_t state_q, state_d;
  logic   zflag_q, zflag_d;
  logic   inc_pc_q, load_pc_q, rd_q, wr_q, load_ir_q, load_acc_q, datactl_ena_q, alu_c_q, halt_q;
  logic   inc_pc_d, load_pc_d, rd_d, wr_d, load_ir_d, load_acc_d, datactl_ena_d, alu_c_d, halt_d;
  logic   alu_op;

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  assign step_rise = step & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  assign alu_op = (opcode == ADD_OP) || (opcode == AND_OP) ||
                  (opcode == XOR_OP) || (opcode == LDA_OP);

  always_comb begin
    state_d       = state_q;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_ir_d     = 1'b0;
    load_acc_d    = 1'b0;
    datactl_ena_d = 1'b0;
    alu_c_d       = 1'b0;
    halt_d        = 1'b0;

    // HALTED is sticky: only reset leaves it, ena has no say.
    if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (!ena) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: state_d = ST_S0;
        ST_S0:   state_d = ST_S1;
        ST_S1:   state_d = ST_S2;
        ST_S2:   state_d = ST_S3;
        ST_S3:   state_d = (opcode == HLT_OP) ? ST_HALTED : ST_S4;
        ST_S4:   state_d = ST_S5;
        ST_S5:   state_d = ST_S6;
        ST_S6:   state_d = ST_S7;
`ifdef SINGLE_STEP_EN
        ST_S7:        state_d = ST_STEP_WAIT;
        ST_STEP_WAIT: state_d = step_rise ? ST_S0 : ST_STEP_WAIT;
`else
        ST_S7:   state_d = ST_S0;
`endif
        default: state_d = ST_WAIT;
      endcase
    end

    // zero is captured once, on the edge into S3; later toggles cannot affect SKZ.
    zflag_d = (state_d == ST_S3) ? zero : zflag_q;

    case (state_d)
      ST_S0, ST_S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      ST_S4: begin
        if (alu_op) begin
          rd_d    = 1'b1;
          alu_c_d = 1'b1;
        end else if (opcode == STO_OP) begin
          datactl_ena_d = 1'b1;
        end else if (opcode == JMP_OP) begin
          load_pc_d = 1'b1;
        end else if (opcode == SKZ_OP) begin
          inc_pc_d = zflag_q;
        end
      end
      ST_S5: begin
        if (alu_op) begin
          rd_d       = 1'b1;
          load_acc_d = 1'b1;
        end else if (opcode == STO_OP) begin
          datactl_ena_d = 1'b1;
          wr_d          = 1'b1;
        end else if (opcode == JMP_OP) begin
          load_pc_d = 1'b1;
        end else if (opcode == SKZ_OP) begin
          inc_pc_d = zflag_q;
        end
      end
      ST_S6: begin
        if (alu_op)                rd_d          = 1'b1;
        else if (opcode == STO_OP) datactl_ena_d = 1'b1;
      end
      ST_HALTED: halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT;
      zflag_q       <= 1'b0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      load_ir_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      datactl_ena_q <= 1'b0;
      alu_c_q       <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      zflag_q       <= zflag_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      load_ir_q     <= load_ir_d;
      load_acc_q    <= load_acc_d;
      datactl_ena_q <= datactl_ena_d;
      alu_c_q       <= alu_c_d;
      halt_q        <= halt_d;
    end
  end

  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_ir     = load_ir_q;
  assign load_acc    = load_acc_q;
  assign datactl_ena = datactl_ena_q;
  assign alu_c       = alu_c_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller (default build): each instruction is expanded into a per-cycle list of
// expected strobes from the opcode/zero rules, then replayed against the DUT cycle by cycle.
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, ANDO = 3'b011;
  localparam logic [2:0] XORO = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  typedef struct packed {
    logic inc_pc, load_pc, rd, wr, load_ir, load_acc, datactl_ena, alu_c, halt;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n, ena, zero;
  logic [2:0] opcode;
  logic       inc_pc, load_pc, rd, wr, load_ir, load_acc, datactl_ena, alu_c, halt;

  int   n_pass = 0, n_fail = 0, n_total = 0, cyc = 0;
  out_t exp_q[$];
  bit   halted_m = 1'b0;
  logic [2:0] cur_op = 3'b101;
  logic zplan = 1'b0;
  int   k_m = 0;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .rd(rd), .wr(wr), .load_ir(load_ir),
    .load_acc(load_acc), .datactl_ena(datactl_ena), .alu_c(alu_c), .halt(halt)
  );

  always #5 clk = ~clk;

  function automatic out_t obs();
    return out_t'({inc_pc, load_pc, rd, wr, load_ir, load_acc, datactl_ena, alu_c, halt});
  endfunction

  task automatic check(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  // Expected strobes for one whole instruction, one entry per cycle starting at the fetch.
  function automatic void plan_instr(input logic [2:0] op, input logic zf);
    out_t f, s;
    exp_q.delete();
    f = '0; f.rd = 1'b1; f.load_ir = 1'b1; f.inc_pc = 1'b1;
    exp_q.push_back(f);
    exp_q.push_back(f);
    exp_q.push_back('0);
    exp_q.push_back('0);
    if (op == HLT) begin
      s = '0; s.halt = 1'b1;
      exp_q.push_back(s);
      return;
    end
    for (int p = 4; p <= 6; p++) begin
      s = '0;
      case (op)
        ADD, ANDO, XORO, LDA: begin
          s.rd = 1'b1; s.alu_c = (p == 4); s.load_acc = (p == 5);
        end
        STO: begin s.datactl_ena = 1'b1; s.wr = (p == 5); end
        JMP: s.load_pc = (p != 6);
        SKZ: s.inc_pc = zf && (p != 6);
        default: ;
      endcase
      exp_q.push_back(s);
    end
    exp_q.push_back('0);
  endfunction

  // One clock: drive inputs at negedge, advance the model, compare #1 after posedge.
  task automatic tick(input logic en_v, input int op_f, input int z_f);
    out_t e, o, hv;
    @(negedge clk);
    cyc++;
    ena = en_v;
    if (!halted_m && en_v && exp_q.size() == 0) begin
      cur_op = (op_f >= 0) ? 3'(op_f) : 3'($urandom_range(1, 7));
      zplan  = (z_f >= 0) ? 1'(z_f) : 1'($urandom_range(0, 1));
      plan_instr(cur_op, zplan);
      k_m = 0;
    end
    opcode = cur_op;
    zero   = (k_m == 3 || k_m == 4) ? zplan : 1'($urandom_range(0, 1));
    hv = '0; hv.halt = 1'b1;
    if (halted_m) e = hv;
    else if (!en_v) begin exp_q.delete(); e = '0; end
    else begin
      e = exp_q.pop_front();
      k_m++;
      if (e.halt) halted_m = 1'b1;
    end
    @(posedge clk);
    #1;
    o = obs();
    check("outputs", o, e);
    check("rd_wr_excl", {8'd0, o.rd & o.wr}, 9'd0);
    check("pc_excl", {8'd0, o.load_pc & o.inc_pc}, 9'd0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 9'd0);
    exp_q.delete();
    halted_m = 1'b0;
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [2:0] op, input int z);
    for (int i = 0; i < 8; i++) tick(1'b1, int'(op), z);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; opcode = 3'b000; zero = 1'b0;
    #12;
    check("reset_state", obs(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(LDA, -1);
    tick(1'b1, int'(LDA), -1);           // immediate refetch after S7
    for (int i = 0; i < 7; i++) tick(1'b1, -1, -1);
    run_instr(STO, -1);
    run_instr(SKZ, 1);
    run_instr(SKZ, 0);
    run_instr(JMP, -1);
    for (int i = 0; i < 5; i++) tick(1'b1, int'(ADD), -1);
    tick(1'b0, -1, -1);                  // ena dropped in S4
    run_instr(JMP, -1);
    for (int i = 0; i < 6; i++) tick(1'b1, int'(STO), -1);
    async_reset();                        // lands mid-S5 while wr is high

    for (int i = 0; i < 400; i++) tick(($urandom_range(0, 15) != 0), -1, -1);

    tick(1'b0, -1, -1);
    for (int i = 0; i < 5; i++) tick(1'b1, int'(HLT), -1);
    for (int i = 0; i < 6; i++) tick(1'(i % 2), -1, -1);
    async_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
